// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the digit-serial arithmetic blocks.
package serial_arith_pkg;

  // Operation sequencing states for the serial adder/subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of run cycles needed to consume a WIDTH-bit operand DIGIT bits at a time.
  function automatic int run_cycles(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width for n run cycles; never narrower than one bit.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Legal parameter combination: DIGIT in 1..WIDTH and dividing WIDTH exactly.
  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_digit_add.sv
// DIGIT-bit combinational ripple adder. Also reports the carry into the digit
// MSB so the caller can form the signed-overflow flag on the final digit.
module serial_digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic c;

  // Ripple the carry through the digit, capturing the carry entering the top bit.
  always_comb begin
    c        = cin;
    s        = '0;
    c_msb_in = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub_p.sv
// Digit-serial adder/subtractor. An operation is accepted in IDLE, processed
// LSB digit first over N = WIDTH/DIGIT RUN cycles, and held in DONE until the
// consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE; neither
// depends combinationally on the opposite side's valid/ready, and once
// out_valid is high the result stays stable until out_ready is seen.
module serial_addsub_p
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int N  = run_cycles(WIDTH, DIGIT);
  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_addsub_p: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, b_sr_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [CW-1:0]     count_q;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_cout, dig_cmsb;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic                   last_digit;

  serial_digit_add #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sr_q[DIGIT-1:0]),
    .b        (b_sr_q[DIGIT-1:0]),
    .cin      (carry_q),
    .s        (dig_s),
    .cout     (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  // New digit enters sum from the MSB side; works unchanged when DIGIT == WIDTH.
  assign sum_cat    = {dig_s, sum_q} >> DIGIT;
  assign last_digit = (count_q == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-derived handshake and status outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
    dbg_state = state_q;
  end

  // Operand load on accept, digit-serial shift/accumulate in RUN, flags on the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr_q  <= a;
            b_sr_q  <= sub ? ~b : b;
            carry_q <= sub;
            count_q <= '0;
          end
        end
        RUN: begin
          a_sr_q  <= a_sr_q >> DIGIT;
          b_sr_q  <= b_sr_q >> DIGIT;
          sum_q   <= sum_cat[WIDTH-1:0];
          carry_q <= dig_cout;
          count_q <= count_q + CW'(1);
          if (last_digit) begin
            cout_q <= dig_cout;
            ovf_q  <= dig_cmsb ^ dig_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_p.sv
// Directed bench for serial_addsub_p: one instance at WIDTH=8/DIGIT=1 and one
// at WIDTH=8/DIGIT=4, a table of hand-computed vectors, plus sequences for
// backpressure and reset mid-operation.
module tb_serial_addsub_p;
  import serial_arith_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_in = '0, b_in = '0;
  logic       sub_in = 1'b0;
  logic       out_ready = 1'b1;
  logic       iv1 = 1'b0, iv4 = 1'b0;

  logic       ir1, ov1, co1, of1, bz1;
  logic       ir4, ov4, co4, of4, bz4;
  logic [7:0] sum1, sum4;
  state_e     st1, st4;

  serial_addsub_p #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a_in), .b(b_in),
    .sub(sub_in), .out_valid(ov1), .out_ready(out_ready), .sum(sum1),
    .cout(co1), .ovf(of1), .busy(bz1), .dbg_state(st1)
  );

  serial_addsub_p #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a_in), .b(b_in),
    .sub(sub_in), .out_valid(ov4), .out_ready(out_ready), .sum(sum4),
    .cout(co4), .ovf(of4), .busy(bz4), .dbg_state(st4)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit         d4;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  function automatic logic sel_ir(input bit d4); return d4 ? ir4 : ir1; endfunction
  function automatic logic sel_ov(input bit d4); return d4 ? ov4 : ov1; endfunction

  // ---------------- driver tasks ----------------
  // Waits (bounded) for in_ready, presents the operation for one accept edge,
  // then scrambles a/b/sub so late sampling would be caught.
  task automatic start_op(input bit d4, input logic [7:0] aa, input logic [7:0] bb,
                          input logic ss);
    int guard = 0;
    while (!sel_ir(d4) && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 40) chk("in_ready_timeout", 32'd1, 32'd0);
    a_in = aa; b_in = bb; sub_in = ss;
    if (d4) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    a_in = 8'($urandom_range(0, 255));
    b_in = 8'($urandom_range(0, 255));
    sub_in = 1'($urandom_range(0, 1));
  endtask

  // Counts cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_done(input bit d4, output int cyc);
    cyc = 0;
    while (!sel_ov(d4) && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic check_result(input bit d4, input logic [7:0] es, input logic ec,
                              input logic eo);
    if (d4) begin
      chk("sum_d4", 32'(sum4), 32'(es));
      chk("cout_d4", 32'(co4), 32'(ec));
      chk("ovf_d4", 32'(of4), 32'(eo));
    end else begin
      chk("sum_d1", 32'(sum1), 32'(es));
      chk("cout_d1", 32'(co1), 32'(ec));
      chk("ovf_d1", 32'(of1), 32'(eo));
    end
  endtask

  // ---------------- test ----------------
  initial begin : main
    int lat;
    int seen;

    //          d4  a      b      sub   sum    cout  ovf
    vecs[0]  = '{0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{0, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = '{0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{0, 8'h55, 8'hAA, 1'b1, 8'hAB, 1'b0, 1'b1};
    vecs[6]  = '{0, 8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[7]  = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8]  = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[10] = '{1, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[11] = '{1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    chk("rst_in_ready", 32'(ir1), 32'd1);
    chk("rst_out_valid", 32'(ov1), 32'd0);
    chk("rst_busy", 32'(bz1), 32'd0);
    chk("rst_sum", 32'(sum1), 32'd0);
    chk("rst_flags", 32'({co1, of1}), 32'd0);
    chk("rst_state", 32'(st1), 32'(IDLE));
    chk("rst_in_ready_d4", 32'(ir4), 32'd1);

    // Table-driven vectors with out_ready held high.
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      start_op(vecs[i].d4, vecs[i].a, vecs[i].b, vecs[i].sub);
      chk(vecs[i].d4 ? "busy_d4" : "busy_d1", 32'(vecs[i].d4 ? bz4 : bz1), 32'd1);
      wait_done(vecs[i].d4, lat);
      chk(vecs[i].d4 ? "latency_d4" : "latency_d1", 32'(lat), vecs[i].d4 ? 32'd2 : 32'd8);
      check_result(vecs[i].d4, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      @(posedge clk); #1;
      chk("back_to_idle", 32'(sel_ir(vecs[i].d4)), 32'd1);
      chk("out_valid_drop", 32'(sel_ov(vecs[i].d4)), 32'd0);
    end

    // Backpressure: result held while out_ready is low and new requests are ignored.
    n_vec++;
    out_ready = 1'b0;
    start_op(0, 8'h3C, 8'h5A, 1'b0);
    wait_done(0, lat);
    chk("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      a_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
      sub_in = 1'($urandom_range(0, 1));
      iv1 = 1'b1;
      @(posedge clk); #1;
      check_result(0, 8'h96, 1'b0, 1'b1);
      chk("bp_in_ready", 32'(ir1), 32'd0);
      chk("bp_out_valid", 32'(ov1), 32'd1);
    end
    iv1 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", 32'(ir1), 32'd1);
    chk("bp_release_valid", 32'(ov1), 32'd0);
    n_vec++;
    start_op(0, 8'h10, 8'h20, 1'b1);
    wait_done(0, lat);
    chk("bp_next_latency", 32'(lat), 32'd8);
    check_result(0, 8'hF0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts the operation.
    n_vec++;
    start_op(0, 8'hFF, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bz1), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(ov1), 32'd0);
    chk("abort_busy", 32'(bz1), 32'd0);
    chk("abort_in_ready", 32'(ir1), 32'd1);
    chk("abort_sum", 32'(sum1), 32'd0);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov1 || bz1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Recovery after abort.
    n_vec++;
    start_op(0, 8'h80, 8'h01, 1'b1);
    wait_done(0, lat);
    chk("recover_latency", 32'(lat), 32'd8);
    check_result(0, 8'h7F, 1'b1, 1'b1);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
